// File: rtl/alu_acc_pkg.sv
// Shared opcode constants and FSM state encoding for the accumulator ALU.
package alu_acc_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_HOLD = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } alu_state_e;

endpackage

// File: rtl/alu_acc_seq_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit consumed per step.
module shift_add_mul #(
    parameter int DATA_W = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod_next,
    output logic                  last
);
    localparam int ACC_W = 2*DATA_W;
    localparam int CNT_W = $clog2(DATA_W);

    logic [ACC_W-1:0]  mcand;
    logic [DATA_W-1:0] mplier;
    logic [ACC_W-1:0]  prod;
    logic [CNT_W-1:0]  cnt;

    // Value the partial product takes after the current step; on the last
    // step this is the final product, so the top can write it directly.
    assign prod_next = mplier[0] ? (prod + mcand) : prod;
    assign last      = (cnt == CNT_W'(DATA_W-1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= ACC_W'(a);
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
        end else if (step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prod_next;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_acc_seq.sv
// Registered accumulator ALU with Start/Busy/Done handshake and iterative multiply.
module alu_acc_seq
    import alu_acc_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [2:0]            Function,
    input  logic [DATA_W-1:0]     Data,
    output logic [2*DATA_W-1:0]   ALUout,
    output logic                  Busy,
    output logic                  Done
);
    localparam int ACC_W = 2*DATA_W;

    alu_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_d;
    logic             acc_we;
    logic             busy_d, done_d;
    logic             mul_load, mul_step, mul_last;
    logic [ACC_W-1:0] mul_prod_next;

    // Single-cycle result; a is the zero-extended low half of the accumulator.
    function automatic logic [ACC_W-1:0] op_result(
        input logic [2:0]       op,
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] acc
    );
        case (op)
            OP_ADD:  op_result = a + b;
            OP_SHL:  op_result = a << DATA_W;
            OP_SUB:  op_result = a - b;
            OP_LOAD: op_result = b;
            OP_CLR:  op_result = '0;
            default: op_result = acc;
        endcase
    endfunction

    shift_add_mul #(.DATA_W(DATA_W)) u_mul (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (mul_load),
        .step      (mul_step),
        .a         (ALUout[DATA_W-1:0]),
        .b         (Data),
        .prod_next (mul_prod_next),
        .last      (mul_last)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = ALUout;
        acc_we   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Function == OP_MUL) begin
                        mul_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        acc_we = 1'b1;
                        acc_d  = op_result(Function, ACC_W'(ALUout[DATA_W-1:0]),
                                           ACC_W'(Data), ALUout);
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    acc_we  = 1'b1;
                    acc_d   = mul_prod_next;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ALUout  <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            Busy    <= busy_d;
            Done    <= done_d;
            if (acc_we) ALUout <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Randomised and directed bench for alu_acc_seq against an arithmetic reference model.
module tb_alu_acc_seq;
    localparam int DW    = 4;
    localparam int AW    = 2*DW;
    localparam int AMASK = (1 << AW) - 1;
    localparam int DMASK = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    func;
    logic [DW-1:0] data;
    logic [AW-1:0] aluout;
    logic          busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_m = 0;

    alu_acc_seq #(.DATA_W(DW)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Start    (start),
        .Function (func),
        .Data     (data),
        .ALUout   (aluout),
        .Busy     (busy),
        .Done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode meanings.
    function automatic int model_op(input int op, input int acc, input int d);
        int a;
        a = acc & DMASK;
        case (op)
            0: return a + d;
            1: return a * d;
            2: return a * (1 << DW);
            4: return (a - d + (1 << AW)) & AMASK;
            5: return d;
            6: return 0;
            default: return acc;
        endcase
    endfunction

    // Issue one op at a negedge, follow it to completion and check everything seen.
    task automatic run_op(input int op, input int d, input bit inject);
        int exp, n;
        exp = model_op(op, acc_m, d);
        start = 1'b1; func = 3'(op); data = DW'(d);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        if (op == 1) begin
            while (busy === 1'b1 && n < 20) begin
                check_eq("mul_hold", aluout, acc_m);
                check_eq("mul_nodone", done, 0);
                n++;
                if (inject && n == 2) begin
                    start = 1'b1; func = 3'b101; data = DW'(4'hA);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check_eq("mul_busy_cycles", n, DW);
        end
        check_eq("op_done", done, 1);
        check_eq("op_busy_low", busy, 0);
        check_eq("op_result", aluout, exp);
        acc_m = exp;
        @(negedge clk);
        check_eq("done_pulse_end", done, 0);
        check_eq("idle_hold", aluout, acc_m);
    endtask

    initial begin
        int op, d, exp;
        rst = 1'b1; start = 1'b0; func = '0; data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_aluout", aluout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_op(5, 5, 0);  check_eq("load5", aluout, 8'h05);
        run_op(0, 11, 0); check_eq("add_b", aluout, 8'h10);
        run_op(2, 0, 0);  check_eq("shl_zero", aluout, 8'h00);
        run_op(5, 15, 0);
        run_op(2, 0, 0);  check_eq("shl_f", aluout, 8'hF0);
        run_op(5, 3, 0);
        run_op(4, 5, 0);  check_eq("sub_wrap", aluout, 8'hFE);
        run_op(6, 9, 0);  check_eq("clr", aluout, 8'h00);
        run_op(5, 6, 0);
        run_op(3, 1, 0);  check_eq("hold011", aluout, 8'h06);
        run_op(7, 2, 0);  check_eq("hold111", aluout, 8'h06);
        run_op(5, 7, 0);
        run_op(1, 9, 0);  check_eq("mul_7x9", aluout, 8'h3F);
        run_op(5, 7, 0);
        run_op(1, 9, 1);  check_eq("mul_ignore_start", aluout, 8'h3F);
        run_op(5, 15, 0);
        run_op(1, 15, 0); check_eq("mul_fxf", aluout, 8'hE1);

        // Reset in the middle of a multiply
        run_op(5, 6, 0);
        start = 1'b1; func = 3'b001; data = 4'h7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_aluout", aluout, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        acc_m = 0;
        @(negedge clk);
        check_eq("after_rst_idle", busy, 0);
        run_op(0, 3, 0);  check_eq("add_after_rst", aluout, 8'h03);

        // Back-to-back single-cycle ops with Start held high
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do op = $urandom_range(0, 7); while (op == 1);
            d = $urandom_range(0, DMASK);
            func = 3'(op); data = DW'(d);
            exp = model_op(op, acc_m, d);
            @(negedge clk);
            check_eq("b2b_done", done, 1);
            check_eq("b2b_result", aluout, exp);
            acc_m = exp;
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("b2b_done_end", done, 0);

        // Random ops including multiply, with occasional idle gaps
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            d  = $urandom_range(0, DMASK);
            run_op(op, d, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                check_eq("gap_done", done, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Registered accumulator ALU, generalised from the 4-bit/8-bit lab ALU.
- `DATA_W`-bit input operand, `2*DATA_W`-bit accumulator.
- Eight operations, including subtract, load and clear.
- Start/Busy/Done handshake.
- Multiply is a multi-cycle shift-add operation instead of a single-cycle combinational multiply.
- Sits between switch/keypad input logic and the HEX display drivers of the lab datapath, and can be reused as a small compute unit elsewhere.

## Interface
Parameters:
- `DATA_W`, default 4: operand width; must be ≥ 2.
- `ACC_W`, fixed at `2*DATA_W`: accumulator width (localparam, not overridable).

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request an operation; sampled only while `Busy`=0.
- `Function`  in  3  opcode, sampled with `Start`.
- `Data`  in  `DATA_W`  operand B, sampled with `Start`.
- `ALUout`  out  `ACC_W`  accumulator (registered).
- `Busy`  out  1  high while a multiply is in progress.
- `Done`  out  1  one-cycle pulse when a result has been written.

## Operation
- Operand A is `ALUout[DATA_W-1:0]`, zero-extended and captured at the Start edge. `Data` is zero-extended to `ACC_W`.
- Opcodes (result written to `ALUout`):
  - 000 ADD: A + Data.
  - 001 MUL: A × Data, multi-cycle.
  - 010 SHL: A << `DATA_W`.
  - 011 HOLD: `ALUout` unchanged.
  - 100 SUB: (A − Data) mod 2^`ACC_W`.
  - 101 LOAD: Data.
  - 110 CLR: 0.
  - 111 HOLD: `ALUout` unchanged.
- All arithmetic is at `ACC_W` bits. ADD/MUL cannot overflow at that width. SUB wraps.
- FSM states:
  - IDLE: `Start`=1 with a non-MUL opcode completes the op in that edge and stays in IDLE. `Start`=1 with MUL captures A and B, clears the partial product and the iteration counter, and goes to MUL.
  - MUL: one shift-add iteration per cycle. The multiplier LSB selects whether the shifted multiplicand is added. The counter counts 0..`DATA_W`−1. The last iteration writes `ALUout`, pulses `Done` and returns to IDLE.
- `ALUout` holds its old value throughout a multiply. There are no intermediate partial products on the output.
- `Start` while `Busy`=1 is ignored entirely; it is not queued.
- `Start`=0 in IDLE: no state change, `Done`=0.
- Reset (any time, including mid-multiply): `ALUout`=0, `Busy`=0, `Done`=0, state IDLE, counter 0, partial product discarded.

## Timing
- Reset values: `ALUout`=0, `Busy`=0, `Done`=0.
- Single-cycle ops: `Start` sampled at edge t0 → `ALUout` updated and `Done`=1 in the cycle after t0. `Done` returns to 0 one cycle later unless another op completes.
- Back-to-back single-cycle ops: `Start` may be held high. Each edge performs one op, and `Done` stays high on consecutive cycles.
- MUL: `Start` at edge t0 → `Busy`=1 from t0 to t`DATA_W`. `ALUout` is written and `Done`=1 after edge t`DATA_W`, with `Busy`=0 in that same cycle. Latency is `DATA_W` cycles.
- A new `Start` is accepted at edge t`DATA_W`+1 at the earliest, i.e. in the cycle where `Done`=1.
- `Busy` and `Done` are never high in the same cycle.

## Structure
- Shared package `alu_acc_pkg`:
  - opcode constants `OP_ADD`, `OP_MUL`, `OP_SHL`, `OP_HOLD`, `OP_SUB`, `OP_LOAD`, `OP_CLR`;
  - state enum `{ST_IDLE, ST_MUL}`.
- One sub-module, `shift_add_mul`, parameterised on `DATA_W`. It holds the multiplicand, multiplier, partial product and counter, and provides load and step inputs and a last-iteration flag.
- The top level owns the FSM, the opcode decode, and the `ALUout`, `Busy` and `Done` registers.

## Test plan
All scenarios use `DATA_W`=4.
- Reset → `ALUout`=0x00, `Busy`=0, `Done`=0. Then LOAD with Data=0x5 → `ALUout`=0x05 and a one-cycle `Done` pulse.
- `ALUout`=0x05, ADD with Data=0xB → 0x10. Then SHL → 0x00 (low nibble 0). Then LOAD 0xF followed by SHL → 0xF0.
- `ALUout`=0x03, SUB with Data=0x5 → 0xFE (wraps). Then CLR → 0x00. HOLD (011 and 111) leaves `ALUout` unchanged and still pulses `Done`.
- `ALUout`=0x07, MUL with Data=0x9:
  - `Busy` is high for exactly 4 cycles and `ALUout` stays 0x07 throughout;
  - then `ALUout`=0x3F with `Done`=1 for one cycle.
  - Also check 0xF × 0xF = 0xE1.
- During a MUL, pulse `Start` with LOAD 0xA → ignored: the MUL result is unaffected and no extra `Done` occurs.
- Assert `Reset` for one cycle at iteration 2 of a MUL → immediate return to `ALUout`=0, `Busy`=0, `Done`=0. A subsequent ADD 0x3 gives 0x03.
